// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction fetch front end with a decode queue,
// pipelined I-cache requests and redirect squashing of in-flight responses.
module fetch_queue_unit #(
   parameter int PC_W = 32,
   parameter int INSTR_W = 32,
   parameter int QDEPTH = 4,
   parameter int MAX_OUT = 2,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                         clk,
   input  logic                         nrst,
   input  logic                         redirect_i,
   input  logic [PC_W-1:0]              redirect_pc_i,
   output logic                         ic_req_valid_o,
   input  logic                         ic_req_ready_i,
   output logic [PC_W-1:0]              ic_req_addr_o,
   input  logic                         ic_resp_valid_i,
   input  logic [INSTR_W-1:0]           ic_resp_instr_i,
   output logic                         dec_valid_o,
   input  logic                         dec_ready_i,
   output logic [INSTR_W-1:0]           dec_instr_o,
   output logic [PC_W-1:0]              dec_pc_o,
   output logic [$clog2(QDEPTH+1)-1:0]  q_count_o
);

   localparam int CW  = $clog2(QDEPTH+1);
   localparam int CW1 = CW + 1;
   localparam int QW  = $clog2(QDEPTH);
   localparam int OW  = $clog2(MAX_OUT+1);
   localparam int PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

   typedef enum logic {RUN, SQUASH} state_t;

   state_t             state;
   logic               run_q;
   logic [PC_W-1:0]    fetch_pc;
   logic [PC_W-1:0]    pend_pc [MAX_OUT];
   logic [PW-1:0]      pend_wr;
   logic [PW-1:0]      pend_rd;
   logic [OW-1:0]      outst;
   logic [OW-1:0]      drop_cnt;
   logic [INSTR_W-1:0] q_instr [QDEPTH];
   logic [PC_W-1:0]    q_pc [QDEPTH];
   logic [QW-1:0]      q_head;
   logic [QW-1:0]      q_tail;
   logic [CW-1:0]      count;

   logic               req_fire;
   logic               resp_fire;
   logic               keep;
   logic               pop;
   logic [OW-1:0]      outst_after;
   logic [CW1-1:0]     credit_sum;
   logic               unused_pc_lsb;

   function automatic logic [PW-1:0] pend_nxt(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUT-1)) ? '0 : p + 1'b1;
   endfunction

   assign unused_pc_lsb = ^redirect_pc_i[1:0];

   // Credit covers queued entries plus in-flight requests, so a kept
   // response always finds a free slot.
   assign credit_sum = CW1'(count) + CW1'(outst);

   assign ic_req_valid_o = run_q & ~redirect_i
                         & (outst < OW'(MAX_OUT))
                         & (credit_sum < CW1'(QDEPTH));
   assign ic_req_addr_o  = fetch_pc;

   assign req_fire    = ic_req_valid_o & ic_req_ready_i;
   assign resp_fire   = ic_resp_valid_i & (outst != '0);
   assign keep        = resp_fire & ~redirect_i & (state == RUN);
   assign outst_after = outst - OW'(resp_fire);

   assign dec_valid_o = (count != '0) & ~redirect_i;
   assign dec_instr_o = q_instr[q_head];
   assign dec_pc_o    = q_pc[q_head];
   assign q_count_o   = count;
   assign pop         = dec_valid_o & dec_ready_i;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state    <= RUN;
         run_q    <= 1'b0;
         fetch_pc <= RESET_PC;
         pend_wr  <= '0;
         pend_rd  <= '0;
         outst    <= '0;
         drop_cnt <= '0;
         q_head   <= '0;
         q_tail   <= '0;
         count    <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            q_pc[i]    <= RESET_PC;
            q_instr[i] <= '0;
         end
      end else begin
         run_q <= 1'b1;
         outst <= outst_after + OW'(req_fire);
         if (req_fire) begin
            pend_pc[pend_wr] <= fetch_pc;
            pend_wr          <= pend_nxt(pend_wr);
         end
         if (resp_fire)
            pend_rd <= pend_nxt(pend_rd);
         if (redirect_i) begin
            fetch_pc <= {redirect_pc_i[PC_W-1:2], 2'b00};
            drop_cnt <= outst_after;
            state    <= (outst_after != '0) ? SQUASH : RUN;
            q_head   <= '0;
            q_tail   <= '0;
            count    <= '0;
         end else begin
            if (req_fire)
               fetch_pc <= fetch_pc + PC_W'(4);
            if (resp_fire && state == SQUASH) begin
               drop_cnt <= drop_cnt - 1'b1;
               if (drop_cnt == OW'(1))
                  state <= RUN;
            end
            if (keep) begin
               q_instr[q_tail] <= ic_resp_instr_i;
               q_pc[q_tail]    <= pend_pc[pend_rd];
               q_tail          <= q_tail + 1'b1;
            end
            if (pop)
               q_head <= q_head + 1'b1;
            count <= count + CW'(keep) - CW'(pop);
         end
      end
   end

endmodule
